load_word_extract_unit: RTL and testbench
=========================================

// Module: load_word_extract_unit
// PURPOSE
// Load-side memory access unit for the MEM stage: accepts one load request, reads the aligned
// 32-bit word from data memory over a variable-latency handshake, then extracts the
// byte/half-word at the low address bits (little endian) and sign-/zero-extends it.
// Holds the result until the pipeline takes it. Flags misaligned loads and memory timeouts.
// PARAMETERS
// ADDR_W        32   byte-address width
// TIMEOUT_CYC   255  max cycles in WAIT before an error response (1..255)
// PORTS
// clk            in   1       clock, rising edge
// rst_n          in   1       asynchronous active-low reset
// req_valid      in   1       load request valid
// req_ready      out  1       unit can accept a request (high only in IDLE)
// req_addr       in   ADDR_W  byte address
// req_type       in   3       0=LB 1=LH 2=LW 4=LBU 5=LHU; 3,6,7 decode as LW
// mem_rd_en      out  1       one-cycle read strobe to data memory
// mem_addr       out  ADDR_W  word address {req_addr[ADDR_W-1:2],2'b00}, held until response
// mem_rd_valid   in   1       memory read data valid (sampled only in WAIT)
// mem_rd_data    in   32      whole word read from memory
// resp_valid     out  1       result valid
// resp_ready     in   1       consumer accepts result
// resp_data      out  32      extended load result; 0 on misalign/timeout
// resp_misalign  out  1       LH/LHU with addr[0]=1, or LW with addr[1:0]!=0
// resp_timeout   out  1       no mem_rd_valid within TIMEOUT_CYC cycles
// busy           out  1       state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; req_ready=1 once out of reset; mem_rd_en=0, mem_addr=0, resp_valid=0,
//   resp_data=0, resp_misalign=0, resp_timeout=0, busy=0. Reset mid-transaction aborts it;
//   any later mem_rd_valid for it is ignored (arrives in IDLE).
// - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
// - IDLE: on req_valid&req_ready latch addr[1:0], type, mem_addr. Misaligned -> RESP directly
//   (resp_misalign=1, resp_data=0, no memory access); else -> ISSUE.
// - ISSUE: mem_rd_en=1 for exactly this cycle; clear timeout counter; -> WAIT.
// - WAIT: counter increments each cycle; mem_rd_valid -> capture extracted data, -> RESP.
//   counter reaches TIMEOUT_CYC without data -> RESP with resp_timeout=1, resp_data=0.
//   mem_rd_valid and timeout in same cycle: data wins, resp_timeout=0.
// - RESP: resp_valid=1, resp_* stable until resp_ready; on resp_valid&resp_ready -> IDLE,
//   resp_valid drops next cycle. req_ready stays 0 until back in IDLE (no back-to-back overlap).
// - Extraction (a = latched addr[1:0], w = mem_rd_data):
//   LB/LBU: byte = w[8a+7:8a]; LB sign-extends bit 7, LBU zero-extends.
//   LH/LHU: half = a[1] ? w[31:16] : w[15:0]; LH sign-extends bit 15, LHU zero-extends.
//   LW: w unchanged.
// - Latency: zero-wait memory (mem_rd_valid the cycle after mem_rd_en) gives resp_valid
//   3 cycles after request accept; misaligned gives resp_valid 1 cycle after accept.
// - mem_rd_valid outside WAIT is ignored; req_valid outside IDLE is not accepted.
// TESTING
// - LB addr=0x1003, word=0x80FF_1234, zero-wait -> mem_addr=0x1000, resp_data=0xFFFF_FF80 at accept+3.
// - LBU addr=0x1003 same word -> 0x0000_0080; LHU addr=0x1002 -> 0x0000_80FF; LH -> 0xFFFF_80FF.
// - LW addr=0x2001 -> resp_misalign=1, resp_data=0, mem_rd_en never asserted, resp_valid at accept+1.
// - LW addr=0x2000, mem_rd_valid after 10 cycles, resp_ready low 4 cycles -> data 0x1234_5678
//   held stable, req_ready=0 throughout, returns IDLE one cycle after handshake.
// - TIMEOUT_CYC=8, no mem_rd_valid -> resp_timeout=1 after 8 WAIT cycles; rerun with
//   mem_rd_valid on cycle 8 -> data returned, resp_timeout=0.
// - rst_n low while in WAIT -> all outputs at reset values immediately; stale mem_rd_valid
//   afterwards produces no response.

Source files
------------

// File: rtl/load_word_extract_unit.sv
// -----------------------------------------------------------------------------
// load_word_extract_unit
//
// Load-side memory access unit for the MEM stage. Accepts one load request,
// reads the aligned 32-bit word from data memory over a variable-latency
// handshake, extracts the byte/half-word selected by the low address bits
// (little endian), and sign- or zero-extends it. The result is held until the
// pipeline accepts it. Misaligned loads are answered without touching memory;
// a memory that never answers is reported as a timeout.
//
// Ports
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   req_valid      in   1       load request valid
//   req_ready      out  1       unit can accept a request (IDLE only)
//   req_addr       in   ADDR_W  byte address
//   req_type       in   3       0=LB 1=LH 2=LW 4=LBU 5=LHU; 3,6,7 act as LW
//   mem_rd_en      out  1       one-cycle read strobe to data memory
//   mem_addr       out  ADDR_W  word-aligned address, held until response
//   mem_rd_valid   in   1       memory read data valid (used only in WAIT)
//   mem_rd_data    in   32      word read from memory
//   resp_valid     out  1       result valid
//   resp_ready     in   1       consumer accepts result
//   resp_data      out  32      extended load result; 0 on misalign/timeout
//   resp_misalign  out  1       misaligned half-word or word access
//   resp_timeout   out  1       memory did not answer within TIMEOUT_CYC
//   busy           out  1       unit is not IDLE
// -----------------------------------------------------------------------------
module load_word_extract_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_misalign,
    output logic              resp_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The WAIT counter starts at 0 in the first WAIT cycle, so the last
    // permitted WAIT cycle is the one where it equals TIMEOUT_CYC-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_r;
    logic [1:0]        ofs_r;
    logic [2:0]        type_r;
    logic [7:0]        cnt_r;
    logic              req_ready_r;
    logic              mem_rd_en_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              resp_valid_r;
    logic [31:0]       resp_data_r;
    logic              resp_misalign_r;
    logic              resp_timeout_r;
    logic              busy_r;

    logic              accept_s;
    logic              misalign_s;

    // Half-word loads need an even address, word loads a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        logic m;
        case (t)
            3'd0, 3'd4: m = 1'b0;
            3'd1, 3'd5: m = a[0];
            default:    m = (a != 2'b00);
        endcase
        return m;
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [31:0] extract(input logic [2:0]  t,
                                            input logic [1:0]  a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h00_0000, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Request acceptance and alignment check of the incoming request.
    always_comb begin
        accept_s   = 1'b0;
        misalign_s = 1'b0;
        if (req_valid && req_ready_r) begin
            accept_s   = 1'b1;
            misalign_s = is_misaligned(req_type, req_addr[1:0]);
        end else begin
            accept_s   = 1'b0;
            misalign_s = 1'b0;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            ofs_r           <= 2'b00;
            type_r          <= 3'd0;
            cnt_r           <= 8'd0;
            req_ready_r     <= 1'b1;
            mem_rd_en_r     <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            resp_valid_r    <= 1'b0;
            resp_data_r     <= 32'h0000_0000;
            resp_misalign_r <= 1'b0;
            resp_timeout_r  <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ofs_r       <= req_addr[1:0];
                        type_r      <= req_type;
                        mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (misalign_s) begin
                            // No memory access: answer straight away.
                            state_r         <= ST_RESP;
                            resp_valid_r    <= 1'b1;
                            resp_data_r     <= 32'h0000_0000;
                            resp_misalign_r <= 1'b1;
                            resp_timeout_r  <= 1'b0;
                        end else begin
                            state_r     <= ST_ISSUE;
                            mem_rd_en_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_rd_en_r <= 1'b0;
                    cnt_r       <= 8'd0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Data arriving in the final WAIT cycle beats the timeout.
                    if (mem_rd_valid) begin
                        state_r         <= ST_RESP;
                        resp_valid_r    <= 1'b1;
                        resp_data_r     <= extract(type_r, ofs_r, mem_rd_data);
                        resp_misalign_r <= 1'b0;
                        resp_timeout_r  <= 1'b0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r         <= ST_RESP;
                        resp_valid_r    <= 1'b1;
                        resp_data_r     <= 32'h0000_0000;
                        resp_misalign_r <= 1'b0;
                        resp_timeout_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r         <= ST_IDLE;
                        resp_valid_r    <= 1'b0;
                        resp_data_r     <= 32'h0000_0000;
                        resp_misalign_r <= 1'b0;
                        resp_timeout_r  <= 1'b0;
                        busy_r          <= 1'b0;
                        req_ready_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    mem_rd_en_r     <= 1'b0;
                    resp_valid_r    <= 1'b0;
                    resp_data_r     <= 32'h0000_0000;
                    resp_misalign_r <= 1'b0;
                    resp_timeout_r  <= 1'b0;
                    busy_r          <= 1'b0;
                    req_ready_r     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign mem_rd_en     = mem_rd_en_r;
    assign mem_addr      = mem_addr_r;
    assign resp_valid    = resp_valid_r;
    assign resp_data     = resp_data_r;
    assign resp_misalign = resp_misalign_r;
    assign resp_timeout  = resp_timeout_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_load_word_extract_unit.sv
// -----------------------------------------------------------------------------
// Testbench for load_word_extract_unit (TIMEOUT_CYC = 8).
// A driver issues loads and plays the memory; expected responses are pushed
// to a scoreboard queue and a separate monitor compares every response.
// -----------------------------------------------------------------------------
module tb_load_word_extract_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_type = 3'd0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_misalign;
    logic        resp_timeout;
    logic        busy;

    load_word_extract_unit #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_misalign(resp_misalign),
        .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        to;
        logic [31:0] maddr;
        int          lat;   // posedges from accept edge to first resp_valid
        int          acc;   // cycle count at the accept edge
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   en_cnt   = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_rd_en) en_cnt <= en_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model built from the load rules with plain arithmetic.
    function automatic exp_t model(input logic [2:0] t, input logic [31:0] a,
                                   input logic [31:0] w, input int d);
        exp_t e;
        int ofs, byt, half, val;
        bit is_b, is_h, sgn;
        ofs  = int'(a % 32'd4);
        byt  = int'((w >> (8 * ofs)) % 32'd256);
        half = int'((w >> (16 * (ofs / 2))) % 32'd65536);
        is_b = (t == 3'd0) || (t == 3'd4);
        is_h = (t == 3'd1) || (t == 3'd5);
        sgn  = (t == 3'd0) || (t == 3'd1);
        if (is_b)      e.mis = 1'b0;
        else if (is_h) e.mis = (ofs % 2) != 0;
        else           e.mis = ofs != 0;
        e.to    = !e.mis && (d == 0 || d > TO);
        e.maddr = a - (a % 32'd4);
        if (is_b)      val = (sgn && byt >= 128) ? byt - 256 : byt;
        else if (is_h) val = (sgn && half >= 32768) ? half - 65536 : half;
        else           val = int'(w);
        e.data = (e.mis || e.to) ? 32'h0 : 32'(val);
        e.lat  = e.mis ? 0 : (e.to ? 1 + TO : 1 + d);
        e.acc  = 0;
        return e;
    endfunction

    // resp_ready driver: random, or held low for the first 4 response cycles.
    initial begin : rdy_drv
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_valid) hold++; else hold = 0;
            if (rdy_mode == 1) resp_ready = (hold > 4);
            else               resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each new response and checks it.
    initial begin : monitor
        exp_t cur;
        bit in_resp, after_hs;
        in_resp  = 1'b0;
        after_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp  = 1'b0;
                after_hs = 1'b0;
            end else if (after_hs) begin
                check("post_hs_resp_valid", 32'(resp_valid), 32'd0);
                check("post_hs_req_ready", 32'(req_ready), 32'd1);
                check("post_hs_busy", 32'(busy), 32'd0);
                after_hs = 1'b0;
            end else if (resp_valid) begin
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'(resp_valid), 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        in_resp = 1'b1;
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end
                if (in_resp) begin
                    check("resp_data", resp_data, cur.data);
                    check("resp_misalign", 32'(resp_misalign), 32'(cur.mis));
                    check("resp_timeout", 32'(resp_timeout), 32'(cur.to));
                    check("mem_addr", mem_addr, cur.maddr);
                    check("resp_req_ready", 32'(req_ready), 32'd0);
                    check("resp_busy", 32'(busy), 32'd1);
                    if (resp_ready) begin
                        in_resp  = 1'b0;
                        after_hs = 1'b1;
                        done_cnt++;
                    end
                end
            end
        end
    end

    // One load: issue, play memory with data on WAIT cycle d (0 = never).
    task automatic do_load(input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] w, input int d);
        exp_t e;
        int e0, d0, k;
        e  = model(t, a, w, d);
        d0 = done_cnt;
        req_addr  = a;
        req_type  = t;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_type  = 3'($urandom_range(0, 7));
        e.acc = cyc;
        e0    = en_cnt;
        sb.push_back(e);
        if (!e.mis && d > 0) begin
            repeat (d) @(posedge clk);
            #1;
            mem_rd_valid = 1'b1;
            mem_rd_data  = w;
            @(posedge clk);
            #1;
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
        end
        k = 0;
        while (done_cnt == d0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("resp_handshake_seen", 32'(done_cnt), 32'(d0 + 1));
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mem_rd_en_pulses", 32'(en_cnt - e0), e.mis ? 32'd0 : 32'd1);
    endtask

    initial begin : driver
        int d, r;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_flags", {30'd0, resp_misalign, resp_timeout}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Extraction examples
        do_load(3'd0, 32'h0000_1003, 32'h80FF_1234, 1);
        do_load(3'd4, 32'h0000_1003, 32'h80FF_1234, 1);
        do_load(3'd5, 32'h0000_1002, 32'h80FF_1234, 1);
        do_load(3'd1, 32'h0000_1002, 32'h80FF_1234, 1);
        // Misaligned word
        do_load(3'd2, 32'h0000_2001, 32'hDEAD_BEEF, 1);
        // Slow memory plus consumer stalling for 4 cycles
        rdy_mode = 1;
        do_load(3'd2, 32'h0000_2000, 32'h1234_5678, 7);
        rdy_mode = 0;
        // Timeout boundary
        do_load(3'd2, 32'h0000_4000, 32'hCAFE_F00D, 0);
        do_load(3'd2, 32'h0000_4004, 32'hCAFE_F00D, TO);
        do_load(3'd6, 32'h0000_4008, 32'hCAFE_F00D, TO + 1);

        // Randomized loads
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = (r == 9) ? TO + 1 : r;
            do_load(3'($urandom_range(0, 7)), $urandom, $urandom, d);
        end

        // Reset while waiting on memory
        req_addr  = 32'h0000_3000;
        req_type  = 3'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_data", resp_data, 32'd0);
        check("midrst_flags", {30'd0, resp_misalign, resp_timeout}, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stale_resp_valid", 32'(resp_valid), 32'd0);
            check("stale_busy", 32'(busy), 32'd0);
        end
        check("stale_req_ready", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
